conv_layer_sequencer: RTL and testbench
=======================================

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_MAPS, default 6, meaning the number of output feature maps per layer run.
REQ-002 SHALL have parameter IMG_W, default 32, meaning the input image width and height in pixels.
REQ-003 SHALL have parameter K, default 5, meaning the convolution kernel size.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports i_start (input, 1, layer-run request) and o_done (output, 1, one-cycle pulse at run end).
REQ-007 SHALL have port o_busy, output, 1, high from run accept to o_done.
REQ-008 SHALL have ports o_img_addr (output, 10, image RAM address), o_img_rd_en (output, 1) and i_img_data (input, 8, valid one cycle after o_img_rd_en).
REQ-009 SHALL have ports o_map_sel (output, 3, weight bank index) and o_wload_start (output, 1, pulse), plus i_wload_done (input, 1, pulse).
REQ-010 SHALL have port o_lc_start, output, 1, one-cycle start pulse to the line controller.
REQ-011 SHALL have ports o_pixel_valid (output, 1), o_pixel (output, 8) and i_pixel_ready (input, 1), as the pixel stream to the line controller.
REQ-012 SHALL have ports i_lc_done (input, 1), i_conv_valid (input, 1) and i_conv_ready (input, 1), observed from the line controller/conv handshake.
REQ-013 SHALL have ports o_map_done (output, 1, pulse per completed map) and o_err (output, 1, sticky window-count mismatch).

Function
REQ-014 SHALL implement states IDLE, WLOAD, LC_START, STREAM, DRAIN, NEXT and FINISH.
REQ-015 SHALL, in IDLE with i_start=1, latch map index 0, assert o_busy and go to WLOAD next cycle.
REQ-016 SHALL ignore i_start while o_busy=1.
REQ-017 SHALL pulse o_wload_start on WLOAD entry with o_map_sel = map index, and hold in WLOAD until i_wload_done.
REQ-018 SHALL pulse o_lc_start for exactly one cycle in LC_START, then enter STREAM.
REQ-019 SHALL, in STREAM, issue o_img_rd_en with address 0..IMG_W*IMG_W-1 in raster order, one read per cycle while no stall is pending.
REQ-020 SHALL present i_img_data on o_pixel with o_pixel_valid exactly one cycle after its read; a pixel transfers when o_pixel_valid and i_pixel_ready are both 1.
REQ-021 SHALL, when i_pixel_ready=0, hold o_pixel/o_pixel_valid stable and capture at most one in-flight RAM word in a 1-entry skid register; no pixel is lost or duplicated.
REQ-022 SHALL enter DRAIN after transferring pixel IMG_W*IMG_W-1, and leave DRAIN on i_lc_done.
REQ-023 SHALL accept i_lc_done arriving in the same cycle as the final pixel transfer, going directly to NEXT.
REQ-024 SHALL, in NEXT, pulse o_map_done; if map index = NUM_MAPS-1 go to FINISH, else increment the index and go to WLOAD.
REQ-025 SHALL, in FINISH, pulse o_done, deassert o_busy and return to IDLE; o_err is held until the next accepted i_start clears it.
REQ-026 SHALL wrap the address counter to 0 at each map start, never beyond 1023.

Reset
REQ-027 SHALL, on reset, force IDLE and drive o_busy, o_done, o_lc_start, o_wload_start, o_img_rd_en, o_pixel_valid, o_map_done and o_err to 0, and o_img_addr, o_pixel and o_map_sel to 0.
REQ-028 SHALL, on reset mid-run, abandon the run with no further pulses after release until a new i_start.

Configuration
REQ-029 SHALL, with SEQ_WINDOW_CHECK_EN defined, count i_conv_valid&&i_conv_ready per map and set o_err if the count is not (IMG_W-K+1)^2 (784 by default) at i_lc_done.
REQ-030 SHALL, without SEQ_WINDOW_CHECK_EN, omit the counter and tie o_err to 0.

Structure
REQ-031 SHALL take the state encoding enum and the defaults IMG_W, K and NUM_MAPS from shared package lenet_fe_pkg.
REQ-032 SHALL place the read-latency and skid logic in sub-module seq_pixel_fetch; the FSM stays in the top level.

Verification
REQ-033 SHALL be verified for a single map: NUM_MAPS=1, ready held high, i_lc_done after the last pixel -> 1024 pixels in order, one o_lc_start, one o_map_done, o_done, o_err=0.
REQ-034 SHALL be verified for full default runs: 6 maps -> o_map_sel steps 0..5, 6 o_wload_start, 6 o_map_done, 6144 pixels, one o_done.
REQ-035 SHALL be verified for backpressure: i_pixel_ready toggled randomly at 50% -> pixel sequence identical to RAM content, with no loss or duplication.
REQ-036 SHALL be verified for the window check: 783 handshakes then i_lc_done -> o_err=1 with the macro defined; o_err=0 without it.
REQ-037 SHALL be verified for reset mid-run: reset asserted during map 2 STREAM -> all outputs 0, IDLE, and no o_done until a new i_start.
REQ-038 SHALL be verified for busy start: i_start pulsed during STREAM -> ignored, and the run completes normally.

Source files
------------

// File: rtl/lenet_fe_pkg.sv
// lenet_fe_pkg: shared defaults and sequencer state encoding for the LeNet front end.
package lenet_fe_pkg;
  localparam int DEF_NUM_MAPS = 6;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_K = 5;
  typedef enum logic [2:0] {IDLE, WLOAD, LC_START, STREAM, DRAIN, NEXT, FINISH} seq_state_e;
  function automatic int win_count(input int img_w, input int k);
    return (img_w - k + 1) * (img_w - k + 1);
  endfunction
endpackage

// File: rtl/seq_pixel_fetch.sv
// seq_pixel_fetch: image RAM read-latency alignment with a 1-entry skid register.
module seq_pixel_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rd_en,
  input  logic [7:0] i_img_data,
  input  logic       i_pixel_ready,
  output logic       o_can_issue,
  output logic       o_pixel_valid,
  output logic [7:0] o_pixel
);
  logic       inflight_q, hold_v_q;
  logic [7:0] hold_q;
  assign o_pixel_valid = hold_v_q | inflight_q;
  assign o_pixel = hold_v_q ? hold_q : (inflight_q ? i_img_data : '0);
  // A new read is safe only if whatever is shown now leaves this cycle, so the skid never overflows.
  assign o_can_issue = !o_pixel_valid || i_pixel_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      inflight_q <= i_rd_en;
      hold_v_q   <= o_pixel_valid && !i_pixel_ready;
      hold_q     <= o_pixel;
    end
  end
endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: runs weight load, line-controller start and pixel streaming per feature map.
// Optional SEQ_WINDOW_CHECK_EN counts conv handshakes per map and flags a mismatch on o_err.
module conv_layer_sequencer
  import lenet_fe_pkg::*;
#(
  parameter int NUM_MAPS = DEF_NUM_MAPS,
  parameter int IMG_W = DEF_IMG_W,
  parameter int K = DEF_K
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  output logic       o_done,
  output logic       o_busy,
  output logic [9:0] o_img_addr,
  output logic       o_img_rd_en,
  input  logic [7:0] i_img_data,
  output logic [2:0] o_map_sel,
  output logic       o_wload_start,
  input  logic       i_wload_done,
  output logic       o_lc_start,
  output logic       o_pixel_valid,
  output logic [7:0] o_pixel,
  input  logic       i_pixel_ready,
  input  logic       i_lc_done,
  input  logic       i_conv_valid,
  input  logic       i_conv_ready,
  output logic       o_map_done,
  output logic       o_err
);
  localparam int NPIX = IMG_W * IMG_W;
  localparam int WIN = win_count(IMG_W, K);
  seq_state_e  state_q, state_d;
  logic [2:0]  map_q, map_d;
  logic [10:0] rd_cnt_q, rd_cnt_d, xfer_cnt_q, xfer_cnt_d;
  logic        wload_start_q, can_issue, xfer, last_xfer, lc_accept;
  seq_pixel_fetch u_fetch (
    .clk           (clk),
    .reset         (reset),
    .i_rd_en       (o_img_rd_en),
    .i_img_data    (i_img_data),
    .i_pixel_ready (i_pixel_ready),
    .o_can_issue   (can_issue),
    .o_pixel_valid (o_pixel_valid),
    .o_pixel       (o_pixel)
  );
  assign o_img_rd_en = state_q == STREAM && rd_cnt_q < 11'(NPIX) && can_issue;
  assign o_img_addr = rd_cnt_q[9:0];
  assign xfer = o_pixel_valid && i_pixel_ready;
  assign last_xfer = xfer && xfer_cnt_q == 11'(NPIX - 1);
  assign lc_accept = i_lc_done && (state_q == DRAIN || (state_q == STREAM && last_xfer));
  assign o_busy = state_q != IDLE;
  assign o_lc_start = state_q == LC_START;
  assign o_map_done = state_q == NEXT;
  assign o_done = state_q == FINISH;
  assign o_map_sel = map_q;
  assign o_wload_start = wload_start_q;
  always_comb begin
    state_d = state_q;
    map_d = map_q;
    rd_cnt_d = rd_cnt_q + 11'(o_img_rd_en);
    xfer_cnt_d = xfer_cnt_q + 11'(xfer);
    case (state_q)
      IDLE: if (i_start) begin
        state_d = WLOAD;
        map_d = '0;
      end
      WLOAD: if (i_wload_done) state_d = LC_START;
      LC_START: begin
        state_d = STREAM;
        rd_cnt_d = '0;
        xfer_cnt_d = '0;
      end
      STREAM: if (last_xfer) state_d = i_lc_done ? NEXT : DRAIN;
      DRAIN: if (i_lc_done) state_d = NEXT;
      NEXT: begin
        state_d = (map_q == 3'(NUM_MAPS - 1)) ? FINISH : WLOAD;
        map_d = (map_q == 3'(NUM_MAPS - 1)) ? map_q : map_q + 3'd1;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      map_q         <= '0;
      rd_cnt_q      <= '0;
      xfer_cnt_q    <= '0;
      wload_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      rd_cnt_q      <= rd_cnt_d;
      xfer_cnt_q    <= xfer_cnt_d;
      wload_start_q <= state_d == WLOAD && state_q != WLOAD;
    end
  end
`ifdef SEQ_WINDOW_CHECK_EN
  logic [15:0] win_cnt_q, win_cnt_d, win_now;
  logic        err_q, err_d;
  always_comb begin
    win_now = win_cnt_q + 16'(i_conv_valid && i_conv_ready);
    win_cnt_d = (state_q == LC_START) ? '0 : win_now;
    err_d = (state_q == IDLE && i_start) ? 1'b0 : err_q | (lc_accept && win_now != 16'(WIN));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      err_q     <= err_d;
    end
  end
  assign o_err = err_q;
`else
  logic unused_conv;
  assign unused_conv = ^{i_conv_valid, i_conv_ready, lc_accept, WIN};
  assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed run table plus reset/busy-start sequences for conv_layer_sequencer.
module tb_conv_layer_sequencer;
  logic       clk = 1'b0, reset = 1'b1, i_start = 1'b0;
  logic       o_done, o_busy, o_img_rd_en, o_wload_start, o_lc_start, o_pixel_valid, o_map_done, o_err;
  logic [9:0] o_img_addr;
  logic [7:0] i_img_data = 8'd0, o_pixel;
  logic [2:0] o_map_sel;
  logic       i_wload_done = 1'b0, i_pixel_ready = 1'b1, i_lc_done = 1'b0;
  logic       i_conv_valid = 1'b0, i_conv_ready = 1'b0;
  always #5 clk = ~clk;
  conv_layer_sequencer dut (
    .clk(clk), .reset(reset), .i_start(i_start), .o_done(o_done), .o_busy(o_busy),
    .o_img_addr(o_img_addr), .o_img_rd_en(o_img_rd_en), .i_img_data(i_img_data),
    .o_map_sel(o_map_sel), .o_wload_start(o_wload_start), .i_wload_done(i_wload_done),
    .o_lc_start(o_lc_start), .o_pixel_valid(o_pixel_valid), .o_pixel(o_pixel),
    .i_pixel_ready(i_pixel_ready), .i_lc_done(i_lc_done), .i_conv_valid(i_conv_valid),
    .i_conv_ready(i_conv_ready), .o_map_done(o_map_done), .o_err(o_err)
  );
`ifdef SEQ_WINDOW_CHECK_EN
  localparam int WCHK = 1;
`else
  localparam int WCHK = 0;
`endif
  int errors = 0, checks = 0;
  int map_pix = 0, pix_total = 0, wload_cnt = 0, lc_cnt = 0, mapd_cnt = 0, done_cnt = 0;
  int lc_cd = 0, wl_cd = 0, hs_budget = 0, lc_delay = 2, hs_n = 784, rnd_mode = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_pix = 8'd0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [7:0] ram_val(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction
  always @(posedge clk) if (o_img_rd_en) i_img_data <= ram_val(int'(o_img_addr));
  always @(posedge clk) begin
    #1;
    i_pixel_ready = rnd_mode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // Monitor and line-controller/weight-loader responders, all sampled mid-cycle.
  always @(negedge clk) begin
    i_lc_done = 1'b0;
    i_wload_done = 1'b0;
    i_conv_valid = hs_budget > 0;
    i_conv_ready = hs_budget > 0;
    if (hs_budget > 0) hs_budget--;
    if (reset) begin
      map_pix = 0; lc_cd = 0; wl_cd = 0; hs_budget = 0; prev_stall = 1'b0;
      i_conv_valid = 1'b0; i_conv_ready = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(o_pixel_valid), 1);
        chk("stall_pixel", int'(o_pixel), int'(prev_pix));
      end
      prev_stall = o_pixel_valid && !i_pixel_ready;
      prev_pix = o_pixel;
      if (lc_cd > 0) begin
        lc_cd--;
        if (lc_cd == 0) i_lc_done = 1'b1;
      end
      if (wl_cd > 0) begin
        wl_cd--;
        if (wl_cd == 0) i_wload_done = 1'b1;
      end
      if (o_pixel_valid && i_pixel_ready) begin
        chk("pixel", int'(o_pixel), int'(ram_val(map_pix)));
        map_pix++;
        pix_total++;
        if (map_pix == 1024) begin
          map_pix = 0;
          if (lc_delay == 0) i_lc_done = 1'b1;
          else lc_cd = lc_delay;
        end
      end
      if (o_wload_start) begin
        chk("map_sel", int'(o_map_sel), wload_cnt);
        wload_cnt++;
        wl_cd = 2;
      end
      if (o_lc_start) begin
        lc_cnt++;
        hs_budget = hs_n;
      end
      if (o_map_done) mapd_cnt++;
      if (o_done) done_cnt++;
    end
  end
  typedef struct {
    int rnd; int lc_delay; int hs_n; int busy_start;
    int exp_pix; int exp_maps; int exp_err;
  } row_t;
  row_t rows[4];
  task automatic check_idle_outputs();
    chk("idle_busy", int'(o_busy), 0);
    chk("idle_done", int'(o_done), 0);
    chk("idle_lc_start", int'(o_lc_start), 0);
    chk("idle_wload_start", int'(o_wload_start), 0);
    chk("idle_rd_en", int'(o_img_rd_en), 0);
    chk("idle_pixel_valid", int'(o_pixel_valid), 0);
    chk("idle_map_done", int'(o_map_done), 0);
    chk("idle_err", int'(o_err), 0);
    chk("idle_addr", int'(o_img_addr), 0);
    chk("idle_pixel", int'(o_pixel), 0);
    chk("idle_map_sel", int'(o_map_sel), 0);
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask
  task automatic run_row(input row_t r);
    rnd_mode = r.rnd; lc_delay = r.lc_delay; hs_n = r.hs_n;
    pix_total = 0; wload_cnt = 0; lc_cnt = 0; mapd_cnt = 0; done_cnt = 0;
    pulse_start();
    chk("busy_after_start", int'(o_busy), 1);
    chk("err_cleared_on_start", int'(o_err), 0);
    if (r.busy_start != 0) begin
      for (int c = 0; c < 5000 && pix_total < 100; c++) @(posedge clk);
      chk("busy_start_reached_stream", int'(pix_total >= 100), 1);
      #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
    end
    for (int c = 0; c < 40000 && done_cnt == 0; c++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("pixels", pix_total, r.exp_pix);
    chk("wload_starts", wload_cnt, r.exp_maps);
    chk("lc_starts", lc_cnt, r.exp_maps);
    chk("map_dones", mapd_cnt, r.exp_maps);
    chk("dones", done_cnt, 1);
    chk("busy_after_done", int'(o_busy), 0);
    chk("err_held", int'(o_err), r.exp_err);
  endtask
  initial begin
    rows[0] = '{0, 3, 784, 0, 6144, 6, 0};
    rows[1] = '{1, 0, 784, 0, 6144, 6, 0};
    rows[2] = '{0, 0, 783, 0, 6144, 6, WCHK};
    rows[3] = '{0, 1, 784, 1, 6144, 6, 0};
    repeat (3) @(negedge clk);
    check_idle_outputs();
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) run_row(rows[i]);
    // Reset in the middle of map 2 streaming must abandon the run silently.
    rnd_mode = 0; lc_delay = 2; hs_n = 784;
    pix_total = 0; wload_cnt = 0; lc_cnt = 0; mapd_cnt = 0; done_cnt = 0;
    pulse_start();
    for (int c = 0; c < 20000 && !(wload_cnt == 3 && map_pix >= 50); c++) @(posedge clk);
    chk("rst_reached_map2", wload_cnt, 3);
    #1 reset = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    @(posedge clk); #1 reset = 1'b0;
    pix_total = 0; mapd_cnt = 0;
    repeat (3000) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_wload", wload_cnt, 3);
    chk("rst_no_pixels", pix_total, 0);
    chk("rst_no_map_done", mapd_cnt, 0);
    chk("rst_idle_busy", int'(o_busy), 0);
    run_row(rows[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
